bound_flasher_param: RTL
========================

BOUND_FLASHER_PARAM -- requirements
Module: bound_flasher_param

Interface
REQ-001 Parameter N, default 16, number of lamps; legal range 8..64.
REQ-002 Parameter MID_LO, default 5, lower kickback/turn point; legal range 0 < MID_LO < MID_HI.
REQ-003 Parameter MID_HI, default 10, upper kickback/turn point; legal range MID_HI < N.
REQ-004 Parameter PRESCALE, default 1, clock cycles per lamp step; legal range 1..2^16-1.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous and active-low.
REQ-007 flick  input  1  start/kickback request, synchronous to clk, level-sampled.
REQ-008 light  output  N  thermometer lamp vector, registered.
REQ-009 busy  output  1  high whenever state is not IDLE, registered.
REQ-010 done  output  1  one-cycle pulse on return to IDLE after DN3, registered.

Function
REQ-011 Internal count c, width clog2(N+1); light SHALL equal the lowest c bits set and all others clear at all times.
REQ-012 States: IDLE, UP1, DN1, UP2, DN2, UP3, DN3, KB; a return register holds UP1 or UP3 while in KB.
REQ-013 Step tick: prescale counter runs only outside IDLE, clears on IDLE exit, asserts a tick every PRESCALE cycles (first tick PRESCALE cycles after IDLE exit).
REQ-014 IDLE: c=0; flick=1 at an edge -> UP1 at that edge, c unchanged; flick=0 -> stay.
REQ-015 Targets/successors: UP1 -> N then DN1; DN1 -> MID_LO then UP2; UP2 -> MID_HI then DN2; DN2 -> 0 then UP3; UP3 -> N then DN3; DN3 -> 0 then IDLE.
REQ-016 Exactly one action per tick: in UP states c<=c+1, in DN/KB states c<=c-1.
REQ-017 State advances on the same tick that c reaches the current target; no dwell at turn points.
REQ-018 Kickback: on a tick in UP1 or UP3 with flick=1 and c equal to MID_LO or MID_HI, c holds, state -> KB, return register <= current state.
REQ-019 KB decrements c per tick; on the tick c reaches 0, state -> return register value; the UP pass restarts from 0 and may kick back again.
REQ-020 flick is ignored in UP2, all DN states and KB, and at all other values of c in UP1/UP3.
REQ-021 done SHALL pulse high for exactly one cycle, the cycle after the DN3 tick that reaches 0.
REQ-022 In IDLE the cycle done is high, flick=1 SHALL start a new sequence (back-to-back runs allowed).
REQ-023 No tick SHALL occur outside IDLE without changing c or state; c never exceeds N nor underflows 0.

Reset
REQ-024 reset_n low SHALL asynchronously force state=IDLE, c=0, prescale counter=0, return register=UP1, light=0, busy=0, done=0.
REQ-025 Reset assertion at any point mid-sequence SHALL abort it; after release the block waits in IDLE for flick.

Verification (N=16, MID_LO=5, MID_HI=10)
REQ-026 PRESCALE=1, one-cycle flick, no further flick -> light steps 0x0001..0xFFFF, down to 0x001F, up to 0x03FF, down to 0x0000, up to 0xFFFF, down to 0x0000; 74 ticks; done one pulse; busy high throughout.
REQ-027 PRESCALE=1, flick=1 on the UP1 tick with light=0x001F -> light holds 0x001F one cycle, then 0x000F..0x0000, then UP1 restarts 0x0001.
REQ-028 PRESCALE=1, flick=1 during UP3 at light=0x03FF -> KB to 0x0000, return to UP3, full DN3 afterwards, done pulses once.
REQ-029 PRESCALE=4 -> each light value held exactly 4 cycles; first change 4 cycles after IDLE exit.
REQ-030 flick held high in DN1 and UP2 -> sequence identical to REQ-026; flick held high continuously -> new run starts in the done cycle.
REQ-031 reset_n pulsed low in DN2 at light=0x00FF -> light=0, busy=0 immediately without waiting for clk; no done pulse.

Source files
------------

// File: rtl/bound_flasher_param.sv
// Bound flasher: a thermometer lamp bar that sweeps a fixed up/down pattern
// after a flick, with optional kickback restarts at the two mid points.
module bound_flasher_param #(
  parameter int N        = 16,
  parameter int MID_LO   = 5,
  parameter int MID_HI   = 10,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flick,
  output logic [N-1:0] light,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_LO    = CW'(MID_LO);
  localparam logic [CW-1:0] C_HI    = CW'(MID_HI);
  localparam logic [CW-1:0] C_LO_P1 = CW'(MID_LO + 1);
  localparam logic [CW-1:0] C_HI_M1 = CW'(MID_HI - 1);
  localparam logic [CW-1:0] C_N_M1  = CW'(N - 1);
  localparam logic [15:0]   P_LAST  = 16'(PRESCALE - 1);

  typedef enum logic [2:0] {
    IDLE,
    UP1,
    DN1,
    UP2,
    DN2,
    UP3,
    DN3,
    KB
  } state_t;

  state_t        state, state_nx;
  state_t        ret, ret_nx;
  logic [CW-1:0] c, c_nx;
  logic [15:0]   pcnt, pcnt_nx;
  logic          done_nx;
  logic          tick;
  logic          kick;

  function automatic logic [N-1:0] therm(input logic [CW-1:0] cnt);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) t[i] = (i < int'(cnt));
    return t;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ret   <= UP1;
      c     <= '0;
      pcnt  <= '0;
      light <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      ret   <= ret_nx;
      c     <= c_nx;
      pcnt  <= pcnt_nx;
      // Outputs are registered from next-state values so they track c/state exactly.
      light <= therm(c_nx);
      busy  <= (state_nx != IDLE);
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ret_nx   = ret;
    c_nx     = c;
    done_nx  = 1'b0;
    tick     = (state != IDLE) && (pcnt == P_LAST);
    kick     = flick && ((c == C_LO) || (c == C_HI));
    if ((state == IDLE) || tick) pcnt_nx = '0;
    else                         pcnt_nx = pcnt + 16'd1;

    // Each branch compares the pre-step count, so "reaches target" is c +/- 1 == target.
    case (state)
      IDLE: begin
        if (flick) state_nx = UP1;
      end
      UP1, UP3: begin
        if (tick) begin
          if (kick) begin
            state_nx = KB;
            ret_nx   = state;
          end else begin
            c_nx = c + C_ONE;
            if (c == C_N_M1) state_nx = (state == UP1) ? DN1 : DN3;
          end
        end
      end
      DN1: begin
        if (tick) begin
          c_nx = c - C_ONE;
          if (c == C_LO_P1) state_nx = UP2;
        end
      end
      UP2: begin
        if (tick) begin
          c_nx = c + C_ONE;
          if (c == C_HI_M1) state_nx = DN2;
        end
      end
      DN2: begin
        if (tick) begin
          c_nx = c - C_ONE;
          if (c == C_ONE) state_nx = UP3;
        end
      end
      DN3: begin
        if (tick) begin
          c_nx = c - C_ONE;
          if (c == C_ONE) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      KB: begin
        if (tick) begin
          c_nx = c - C_ONE;
          if (c == C_ONE) state_nx = ret;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
